// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, funct codes,
// sequencer state encoding, ALU operation encoding and a sign-extend helper.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, r0 reads as zero and ignores writes, whole array cleared on reset.
module mc_regfile
    import mc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [0:31];

    // Clear on reset, otherwise write one register (never r0).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/mc_mips_core.sv
// Multicycle MIPS core (add/sub/and/or/slt, addi, lw, sw, beq, j).
// One ALU and one valid/ready memory port are shared across sequencer states.
// Optional feature macro: MC_TRAP_EN -- illegal instructions and misaligned
// lw/sw halt the core; when undefined they act as NOP / are force-aligned.
module mc_mips_core
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              retire,
    output logic              halted
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] mdr_q, mdr_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] imm_sx;

    logic [31:0] rf_rd1, rf_rd2, rf_wd;
    logic        rf_we;
    logic [4:0]  rf_wa;

    alu_op_t     alu_op, r_alu_op;
    logic [31:0] alu_a, alu_b, alu_r;
    logic        r_legal;
    logic        trap;
    logic [31:0] byte_addr;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign imm16  = ir_q[15:0];
    assign imm26  = ir_q[25:0];
    assign imm_sx = sext16(imm16);

    function automatic logic [31:0] alu(input alu_op_t f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return x + y;
        endcase
    endfunction

    mc_regfile u_rf (
        .clk_i (CLK),
        .rst_i (reset),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rf_rd1),
        .rd2_o (rf_rd2),
        .we_i  (rf_we),
        .wa_i  (rf_wa),
        .wd_i  (rf_wd)
    );

    // Decode R-type funct into an ALU operation and legality flag.
    always_comb begin
        r_alu_op = ALU_ADD;
        r_legal  = 1'b1;
        case (funct)
            FN_ADD:  r_alu_op = ALU_ADD;
            FN_SUB:  r_alu_op = ALU_SUB;
            FN_AND:  r_alu_op = ALU_AND;
            FN_OR:   r_alu_op = ALU_OR;
            FN_SLT:  r_alu_op = ALU_SLT;
            default: r_legal  = 1'b0;
        endcase
    end

    // Shared ALU operand steering: branch target in DECODE, real work in EXEC.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = a_q;
        alu_b  = imm_sx;
        if (state_q == ST_DECODE) begin
            alu_a = pc_q;
            alu_b = {imm_sx[29:0], 2'b00};
        end else if (op == OP_R) begin
            alu_op = r_alu_op;
            alu_b  = b_q;
        end else if (op == OP_BEQ) begin
            alu_op = ALU_SUB;
            alu_b  = b_q;
        end
    end

    assign alu_r = alu(alu_op, alu_a, alu_b);

`ifdef MC_TRAP_EN
    logic op_legal;
    logic addr_mis;
    assign op_legal = ((op == OP_R) && r_legal) || (op == OP_LW) || (op == OP_SW) ||
                      (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    assign addr_mis = ((op == OP_LW) || (op == OP_SW)) && (alu_r[1:0] != 2'b00);
    assign trap     = (state_q == ST_EXEC) && (!op_legal || addr_mis);
`else
    assign trap     = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state logic; memory states wait indefinitely for ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (trap)
                    state_d = ST_HALT;
                else if (((op == OP_R) && r_legal) || (op == OP_ADDI))
                    state_d = ST_WB;
                else if ((op == OP_LW) || (op == OP_SW))
                    state_d = ST_MEM;
                else
                    state_d = ST_FETCH;
            end
            ST_MEM:    if (mem_ready) state_d = (op == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:     state_d = ST_FETCH;
`ifdef MC_TRAP_EN
            ST_HALT:   state_d = ST_HALT;
`endif
            default:   state_d = ST_FETCH;
        endcase
    end

    // Sequencer outputs: memory request, retire pulse and register write-back.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        byte_addr = pc_q;
        retire    = 1'b0;
        rf_we     = 1'b0;
        rf_wa     = rt;
        rf_wd     = aluout_q;
        case (state_q)
            ST_FETCH: mem_req = 1'b1;
            ST_EXEC:  retire  = (state_d == ST_FETCH);
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_SW);
                byte_addr = {aluout_q[31:2], 2'b00};
                retire    = (state_d == ST_FETCH);
            end
            ST_WB: begin
                retire = 1'b1;
                rf_we  = 1'b1;
                rf_wa  = (op == OP_R) ? rd : rt;
                rf_wd  = (op == OP_LW) ? mdr_q : aluout_q;
            end
            default: ;
        endcase
    end

    // Datapath next-state: what each architectural/internal register loads.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d = mem_rdata;
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_DECODE: begin
                a_d      = rf_rd1;
                b_d      = rf_rd2;
                aluout_d = alu_r;
            end
            ST_EXEC: begin
                if (!trap) begin
                    if (op == OP_BEQ) begin
                        if (alu_r == 32'd0) pc_d = aluout_q;
                    end else if (op == OP_J) begin
                        pc_d = {pc_q[31:28], imm26, 2'b00};
                    end else begin
                        aluout_d = alu_r;
                    end
                end
            end
            ST_MEM: begin
                if (mem_ready && (op == OP_LW)) mdr_d = mem_rdata;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
            mdr_q    <= 32'd0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    assign mem_addr  = byte_addr[ADDR_W-1:0];
    assign mem_wdata = b_q;
    assign pc        = pc_q;
`ifdef MC_TRAP_EN
    assign halted    = (state_q == ST_HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule
